cla_nibble_sequencer: RTL and testbench

- Multi-cycle WIDTH-bit adder front/back end for the 4-bit carry-lookahead carry block.
- Captures one operand pair via valid/ready and issues one nibble per cycle, LSB first.
- For each nibble it drives group propagate/generate and carry-in to the carry block, then consumes the returned internal carries and group carry-out.
- Assembles the sum and presents it with carry-out and signed overflow through a valid/ready output handshake.

---
 rtl/cla_nibble_sequencer.sv | 86 ++++++++
 tb/tb_cla_nibble_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cla_nibble_sequencer.sv
// cla_nibble_sequencer: multi-cycle WIDTH-bit adder that walks operands one nibble per cycle
// through an external 4-bit carry-lookahead block and returns sum/cout/ovf via valid/ready.
module cla_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       p,
    output logic [3:0]       g,
    output logic             ci,
    input  logic [3:1]       c,
    input  logic             cout_blk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_run;
    logic             w_last;

    always_comb begin
        w_run     = r_state == RUN;
        w_last    = r_idx == IW'(NIB - 1);
        p         = w_run ? r_a[4*r_idx +: 4] ^ r_b[4*r_idx +: 4] : 4'd0;
        g         = w_run ? r_a[4*r_idx +: 4] & r_b[4*r_idx +: 4] : 4'd0;
        ci        = w_run ? r_carry : 1'b0;
        in_ready  = r_state == IDLE;
        out_valid = r_state == DONE;
        sum       = r_sum;
        cout      = r_cout;
        ovf       = r_ovf;
    end

    // carry block responses are consumed only while RUN drives p/g/ci
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
                r_state <= RUN;
            end
        end else if (w_run) begin
            r_sum[4*r_idx +: 4] <= p ^ {c, r_carry};
            r_carry             <= cout_blk;
            r_idx               <= r_idx + 1'b1;
            if (w_last) begin
                r_cout  <= cout_blk;
                r_ovf   <= c[3] ^ cout_blk;
                r_state <= DONE;
            end
        end else if (out_ready) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// tb_cla_nibble_sequencer: randomized self-checking bench with an arithmetic carry-block model
// and an a+b+cin reference for every transaction.
module tb_cla_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [3:0]       p;
    logic [3:0]       g;
    logic             ci;
    logic [3:1]       c;
    logic             cout_blk;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [4:0]       w_t;
    int               n_chk = 0;
    int               n_pass = 0;

    cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .p(p), .g(g), .ci(ci), .c(c), .cout_blk(cout_blk),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // nibble add as a+b = (a^b) + 2(a&b); carry into bit j is sum bit j xor p[j]
    always_comb begin
        w_t      = 5'(p) + {g, 1'b0} + 5'(ci);
        c        = w_t[3:1] ^ p[3:1];
        cout_blk = w_t[4];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_add(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                          input int stall, input bit rand_rdy);
        logic [16:0] full;
        logic [31:0] mk;
        logic [15:0] s_hold;
        logic        e_ovf;
        int          n;
        full  = 17'(ta) + 17'(tb) + 17'(tc);
        e_ovf = (ta[15] == tb[15]) && (full[15] != ta[15]);
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            mk = (32'd1 << (4 * n)) - 32'd1;
            chk("ci_run", 32'(ci), ((32'(ta) & mk) + (32'(tb) & mk) + 32'(tc)) >> (4 * n));
            chk("p_run", 32'(p), 32'((ta ^ tb) >> (4 * n)) & 32'hF);
            chk("in_ready_run", 32'(in_ready), 32'd0);
            out_ready = rand_rdy ? 1'($urandom) : 1'b0;
            n++;
            @(negedge clk);
        end
        chk("latency", 32'(n), 32'(NIB));
        out_ready = 1'b0;
        chk("sum", 32'(sum), 32'(full[15:0]));
        chk("cout", 32'(cout), 32'(full[16]));
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("pgci_done", {23'd0, p, g, ci}, 32'd0);
        chk("in_ready_done", 32'(in_ready), 32'd0);
        s_hold = sum;
        for (int i = 0; i < stall; i++) begin
            in_valid = rand_rdy ? 1'($urandom) : 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", {15'd0, cout, ovf, sum}, {15'd0, full[16], e_ovf, s_hold});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_outs", {12'd0, out_valid, cout, ovf, p, g, ci, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_add(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        do_add(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        do_add(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        do_add(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        do_add(16'hA5C3, 16'h5A3D, 1'b1, 10, 1'b0);
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_outs", {12'd0, out_valid, cout, ovf, p, g, ci, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_add(16'h0001, 16'h0001, 1'b0, 1, 1'b0);
        for (int k = 0; k < 1000; k++)
            do_add(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
